am2950_port: RTL

Single-clock bidirectional handshake I/O port: two WIDTH-bit holding registers with full flags connect the CPU-side bus (A) and the peripheral-side bus (B). S carries data A→B; R carries data B→A. Each side loads its outbound register and acknowledges its inbound register. This block is the unloading/handshaking counterpart to the plain enabled registers in the library, sitting between a bitslice datapath and an external device.

---
 rtl/am2950_port_if.sv | 15 +
 rtl/am2950_port.sv | 54 +++++
 2 files changed

// File: rtl/am2950_port_if.sv
// am2950_port_if: CPU-side (a_*) and peripheral-side (b_*) strobes, data and flags of the am2950 port.
interface am2950_port_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
    logic a_wr_, a_rd_, b_wr_, b_rd_;
    logic fs, fr, ovs, ovr;
    logic ien_, int_;
    modport master (
        output a_d, a_wr_, a_rd_, b_d, b_wr_, b_rd_, ien_,
        input  a_q, b_q, fs, fr, ovs, ovr, int_
    );
    modport slave (
        input  a_d, a_wr_, a_rd_, b_d, b_wr_, b_rd_, ien_,
        output a_q, b_q, fs, fr, ovs, ovr, int_
    );
endinterface

// File: rtl/am2950_port.sv
// am2950_port: bidirectional handshake port, S carries A->B and R carries B->A, each with a full flag and sticky overrun.
// Interrupt logic is built only when AM2950_INT_EN is defined; otherwise int_ is tied high.
module am2950_port #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_,
    am2950_port_if.slave p
);
    logic [WIDTH-1:0] s, r;
    logic fs, fr, ovs, ovr;
    // A write that lands while the peer acknowledges in the same edge is not an overrun.
    always_ff @(posedge clk or negedge rst_)
        if (!rst_) begin
            s <= '0;
            r <= '0;
            fs <= 1'b0;
            fr <= 1'b0;
            ovs <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (!p.a_wr_) begin
                if (!fs || !p.b_rd_) begin
                    s <= p.a_d;
                    fs <= 1'b1;
                    ovs <= 1'b0;
                end else ovs <= 1'b1;
            end else if (!p.b_rd_) begin
                fs <= 1'b0;
                ovs <= 1'b0;
            end
            if (!p.b_wr_) begin
                if (!fr || !p.a_rd_) begin
                    r <= p.b_d;
                    fr <= 1'b1;
                    ovr <= 1'b0;
                end else ovr <= 1'b1;
            end else if (!p.a_rd_) begin
                fr <= 1'b0;
                ovr <= 1'b0;
            end
        end
    assign p.b_q = s;
    assign p.a_q = r;
    assign p.fs = fs;
    assign p.fr = fr;
    assign p.ovs = ovs;
    assign p.ovr = ovr;
`ifdef AM2950_INT_EN
    assign p.int_ = ~(~p.ien_ & (fr | ~fs));
`else
    logic unused_ien;
    assign unused_ien = p.ien_;
    assign p.int_ = 1'b1;
`endif
endmodule
